sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (port I) and the MEM-stage data requester (port D).
- Sits between the IF/MEM pipeline stages and the single memory interface.
- Serialises accesses with one outstanding transaction at a time.
- Uses the req / addr_ok / data_ok handshake upstream and downstream.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STRB_W, DATA_W/8, byte-strobe width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- i_req  in  1  instruction request
- i_addr  in  ADDR_W  instruction address
- i_addr_ok  out  1  instruction request accepted (1-cycle pulse)
- i_data_ok  out  1  instruction read data valid (1-cycle pulse)
- i_rdata  out  DATA_W  instruction read data
- d_req  in  1  data request
- d_wr  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_wstrb  in  STRB_W  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_addr_ok  out  1  data request accepted (pulse)
- d_data_ok  out  1  load data valid / store complete (pulse)
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request
- m_wr  out  1  memory write
- m_size  out  2  memory access size
- m_wstrb  out  STRB_W  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_addr_ok  in  1  memory accepted request
- m_data_ok  in  1  memory response valid
- m_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, RESP. The grant register `gnt` (0 = I, 1 = D) and the captured request fields (wr, size, wstrb, addr, wdata) are registered.
- IDLE: if d_req or i_req is high, select a winner (default fixed priority: D over I) and capture its fields. For an I winner, capture wr=0, size=2, wstrb=0, wdata=0. Pulse the winner's x_addr_ok in the same cycle, then go to REQ. The loser sees no addr_ok and must hold its req.
- REQ: m_req=1 with the captured fields, held stable until m_addr_ok. On m_addr_ok go to RESP.
- RESP: m_req=0. On m_data_ok, drive x_data_ok = m_data_ok & (gnt matches) combinationally, with x_rdata = m_rdata. Return to IDLE next cycle.
- i_rdata and d_rdata always carry m_rdata; they are meaningful only while the matching data_ok is high.
- Minimum latency, req to data_ok: 3 cycles when m_addr_ok and m_data_ok arrive at the earliest point.
- Back-to-back: a new grant is possible in the first IDLE cycle after data_ok.
- Stores complete via d_data_ok exactly like loads; d_rdata is don't-care.
- m_data_ok in IDLE or REQ is a protocol error. It is ignored and no data_ok is forwarded.
- addr_ok and data_ok are never high together for the same port within one transaction.
- Reset (asynchronous, any cycle including mid-transaction):
  - state=IDLE, gnt=0.
  - Captured fields cleared to 0.
  - All outputs 0: m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata, all x_addr_ok, all x_data_ok.
  - An abandoned memory response after reset release arrives in IDLE and is therefore dropped.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requests are high in IDLE, the port not granted last wins. A `last_gnt` register resets to 0 (I), so D wins the first tie. last_gnt updates on every grant.
- Undefined: fixed priority, D always wins ties. No last_gnt register.

Decomposition:
- Shared package: state encodings (ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_RESP=2'd2), the size constants (SZ_B/SZ_H/SZ_W), and the GNT_I/GNT_D constants.
- One natural sub-module, arb_pick: the combinational winner select (fixed or round-robin), taking i_req, d_req and last_gnt and producing gnt_next and the valid grant.

Test Plan:
- Lone load: d_req=1, d_wr=0, d_addr=0x1C000010. Expect d_addr_ok in cycle 0 and m_req/m_addr=0x1C000010 in cycle 1. With m_addr_ok in cycle 1 and m_data_ok=1, m_rdata=0xDEADBEEF in cycle 2, expect d_data_ok=1 and d_rdata=0xDEADBEEF in cycle 2.
- Tie, fixed priority: i_req=d_req=1 in the same cycle. Expect D served first, then I granted in the IDLE cycle after d_data_ok, with i_addr=0x1C000000 on m_addr.
- Tie, ARB_ROUND_ROBIN_EN, both held high for 4 transactions. Expect the grant order D, I, D, I.
- Store with stall: d_wr=1, d_size=0, d_wstrb=4'b0100, d_wdata=0x00AB0000. Hold m_addr_ok=0 for 5 cycles; expect m_req and all fields stable throughout, then d_data_ok on the response.
- Async reset: drop resetn while in RESP. Expect all outputs 0 immediately. After release, a stray m_data_ok must produce no i/d_data_ok.
- Stray response: m_data_ok=1 while in IDLE. Expect no data_ok pulses and the state to remain IDLE.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for sram_bus_arbiter: FSM states, access sizes and grant ids.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/sram_bus_arbiter_pick.sv
// Combinational winner select for the I/D ports of sram_bus_arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise D always wins ties.
module arb_pick
    import sram_bus_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_gnt,
    output logic gnt_next,
    output logic gnt_valid
);

    assign gnt_valid = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time is served.
    always_comb begin
        if (i_req && d_req) begin
            gnt_next = (last_gnt == GNT_D) ? GNT_I : GNT_D;
        end else begin
            gnt_next = d_req ? GNT_D : GNT_I;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
    assign gnt_next        = d_req ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction (I) and data (D) requesters,
// one outstanding transaction at a time. Optional macro: ARB_ROUND_ROBIN_EN.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [STRB_W-1:0] d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [STRB_W-1:0] m_wstrb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,
    output arb_state_e        dbg_state
);

    // Handshake: a requester holds req and its fields until it sees addr_ok
    // (1-cycle pulse); the matching data_ok pulse later ends the transaction.
    arb_state_e        state_q, state_d;
    logic              gnt_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_gnt, pick_valid, last_gnt;
    logic              grant_en;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt_q <= GNT_I;
        end else if (grant_en) begin
            last_gnt_q <= pick_gnt;
        end
    end

    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = GNT_I;
`endif

    arb_pick u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_gnt  (last_gnt),
        .gnt_next  (pick_gnt),
        .gnt_valid (pick_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= GNT_I;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                gnt_q <= pick_gnt;
                if (pick_gnt == GNT_D) begin
                    wr_q    <= d_wr;
                    size_q  <= d_size;
                    wstrb_q <= d_wstrb;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end else begin
                    wr_q    <= 1'b0;
                    size_q  <= SZ_W;
                    wstrb_q <= '0;
                    addr_q  <= i_addr;
                    wdata_q <= '0;
                end
            end
        end
    end

    // addr_ok is combinational from req, so it is gated by resetn to stay low in reset.
    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        i_addr_ok = 1'b0;
        d_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid && resetn) begin
                    grant_en  = 1'b1;
                    d_addr_ok = (pick_gnt == GNT_D);
                    i_addr_ok = (pick_gnt == GNT_I);
                    state_d   = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (m_addr_ok) state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (m_data_ok) begin
                    d_data_ok = (gnt_q == GNT_D);
                    i_data_ok = (gnt_q == GNT_I);
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign m_req     = (state_q == ARB_REQ);
    assign m_wr      = wr_q;
    assign m_size    = size_q;
    assign m_wstrb   = wstrb_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model (granted / accepted queues and a tie-break rule).
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    localparam int TXN_W = 1 + 1 + 2 + 4 + 32 + 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    arb_state_e  dbg_state;

    // clock / reset block
    always #5 clk = ~clk;

    sram_bus_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_wstrb   (d_wstrb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_wstrb   (m_wstrb),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .dbg_state (dbg_state)
    );

    // scoreboard: granted-but-not-accepted requests and accepted-but-unanswered ports
    logic [TXN_W-1:0] exp_q[$];
    logic             rsp_q[$];
    logic             grant_log[$];
    logic             last_win;
    logic             i_granted, d_granted;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return (last_win == GNT_D) ? GNT_I : GNT_D;
`else
        return GNT_D;
`endif
    endfunction

    // One clock cycle: inputs are already driven; check at negedge, advance the model.
    task automatic step();
        logic             exp_i_ok, exp_d_ok, exp_i_dok, exp_d_dok, win;
        logic [TXN_W-1:0] txn;
        @(negedge clk);
        exp_i_ok = 1'b0;
        exp_d_ok = 1'b0;
        win      = GNT_I;
        if (exp_q.size() == 0 && rsp_q.size() == 0 && (i_req || d_req)) begin
            win = (i_req && d_req) ? tie_winner() : (d_req ? GNT_D : GNT_I);
            exp_d_ok = (win == GNT_D);
            exp_i_ok = (win == GNT_I);
        end
        exp_i_dok = (rsp_q.size() != 0) && m_data_ok && (rsp_q[0] == GNT_I);
        exp_d_dok = (rsp_q.size() != 0) && m_data_ok && (rsp_q[0] == GNT_D);
        chk("i_addr_ok", i_addr_ok, exp_i_ok);
        chk("d_addr_ok", d_addr_ok, exp_d_ok);
        chk("m_req", m_req, exp_q.size() != 0);
        if (exp_q.size() != 0)
            chk("m_fields", {m_wr, m_size, m_wstrb, m_addr, m_wdata}, exp_q[0][TXN_W-2:0]);
        chk("i_data_ok", i_data_ok, exp_i_dok);
        chk("d_data_ok", d_data_ok, exp_d_dok);
        if (exp_i_dok) chk("i_rdata", i_rdata, m_rdata);
        if (exp_d_dok) chk("d_rdata", d_rdata, m_rdata);
        if (d_addr_ok) grant_log.push_back(GNT_D);
        if (i_addr_ok) grant_log.push_back(GNT_I);

        if (rsp_q.size() != 0 && m_data_ok) void'(rsp_q.pop_front());
        if (exp_q.size() != 0 && m_addr_ok) begin
            txn = exp_q.pop_front();
            rsp_q.push_back(txn[TXN_W-1]);
        end
        if (exp_d_ok) begin
            exp_q.push_back({GNT_D, d_wr, d_size, d_wstrb, d_addr, d_wdata});
            d_granted = 1'b1;
        end
        if (exp_i_ok) begin
            exp_q.push_back({GNT_I, 1'b0, SZ_W, 4'b0, i_addr, 32'b0});
            i_granted = 1'b1;
        end
        if (exp_i_ok || exp_d_ok) last_win = win;
        @(posedge clk);
        #1;
    endtask

    // driver task: optional random requesters, memory either fastest or random
    task automatic run_cycles(input int n, input bit rand_req, input bit fast_mem);
        for (int c = 0; c < n; c++) begin
            if (rand_req) begin
                if (i_granted || !i_req) begin
                    i_req  = ($urandom_range(0, 2) == 0);
                    i_addr = $urandom() & 32'hFFFF_FFFC;
                end
                if (d_granted || !d_req) begin
                    d_req   = ($urandom_range(0, 2) == 0);
                    d_wr    = 1'($urandom_range(0, 1));
                    d_size  = ($urandom_range(0, 2) == 0) ? SZ_B : (($urandom_range(0, 1) == 0) ? SZ_H : SZ_W);
                    d_wstrb = 4'($urandom());
                    d_addr  = $urandom();
                    d_wdata = $urandom();
                end
            end
            i_granted = 1'b0;
            d_granted = 1'b0;
            if (fast_mem) begin
                m_addr_ok = (exp_q.size() != 0);
                m_data_ok = (rsp_q.size() != 0);
            end else begin
                m_addr_ok = (exp_q.size() != 0) && ($urandom_range(0, 1) == 1);
                m_data_ok = (rsp_q.size() != 0) ? ($urandom_range(0, 1) == 1)
                                                 : ($urandom_range(0, 15) == 0);
            end
            m_rdata = $urandom();
            step();
        end
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
    endtask

    // Called at posedge+1; asserts reset asynchronously and checks outputs go quiet.
    task automatic do_reset();
        resetn    = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        #1;
        chk("rst_outputs", {m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
                            i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, '0);
        chk("rst_state", dbg_state, ARB_IDLE);
        exp_q.delete();
        rsp_q.delete();
        last_win = GNT_I;
        @(posedge clk);
        #1;
        chk("rst_outputs_hold", {m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
                                 i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, '0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        {i_req, d_req, d_wr, m_addr_ok, m_data_ok} = '0;
        i_addr = '0; d_size = '0; d_wstrb = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        i_granted = 1'b0; d_granted = 1'b0; last_win = GNT_I;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // lone load at earliest memory timing
        d_req = 1'b1; d_wr = 1'b0; d_size = SZ_W; d_wstrb = 4'h0;
        d_addr = 32'h1C00_0010; d_wdata = 32'h0;
        #1 chk("ll_addr_ok_c0", d_addr_ok, 1'b1);
        step();
        d_req = 1'b0; m_addr_ok = 1'b1;
        #1 chk("ll_m_req_c1", {m_req, m_addr}, {1'b1, 32'h1C00_0010});
        step();
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        #1 chk("ll_data_c2", {d_data_ok, d_rdata}, {1'b1, 32'hDEAD_BEEF});
        step();
        m_data_ok = 1'b0;
        step();

        // tie with D dropping after its grant: I follows, I address reaches memory
        do_reset();
        grant_log.delete();
        i_req = 1'b1; i_addr = 32'h1C00_0000;
        d_req = 1'b1; d_addr = 32'h1C00_0100;
        step();
        d_req = 1'b0;
        run_cycles(3, 1'b0, 1'b1);
        i_req = 1'b0;
        chk("tie_i_addr", {m_req, m_addr}, {1'b1, 32'h1C00_0000});
        run_cycles(3, 1'b0, 1'b1);
        chk("tie_order", {grant_log.size(), grant_log[0], grant_log[1]}, {32'd2, GNT_D, GNT_I});

        // both held for four transactions
        do_reset();
        grant_log.delete();
        i_req = 1'b1; d_req = 1'b1;
        run_cycles(12, 1'b0, 1'b1);
        i_req = 1'b0; d_req = 1'b0;
        run_cycles(3, 1'b0, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
        chk("hold4_order", {grant_log.size(), grant_log[0], grant_log[1], grant_log[2], grant_log[3]},
            {32'd4, GNT_D, GNT_I, GNT_D, GNT_I});
`else
        chk("hold4_order", {grant_log.size(), grant_log[0], grant_log[1], grant_log[2], grant_log[3]},
            {32'd4, GNT_D, GNT_D, GNT_D, GNT_D});
`endif

        // byte store with a 5-cycle memory stall
        d_req = 1'b1; d_wr = 1'b1; d_size = SZ_B; d_wstrb = 4'b0100;
        d_addr = 32'h1C00_0022; d_wdata = 32'h00AB_0000;
        step();
        d_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("st_stall", {m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata},
                   {1'b1, 1'b1, SZ_B, 4'b0100, 32'h1C00_0022, 32'h00AB_0000});
            step();
        end
        m_addr_ok = 1'b1;
        step();
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = $urandom();
        #1 chk("st_done", {d_data_ok, i_data_ok}, 2'b10);
        step();
        m_data_ok = 1'b0;
        step();

        // reset while waiting for a response; the late response must be dropped
        d_req = 1'b1; d_wr = 1'b0; d_size = SZ_W; d_addr = 32'h1C00_0040;
        step();
        d_req = 1'b0; m_addr_ok = 1'b1;
        step();
        m_addr_ok = 1'b0;
        #1 chk("pre_rst_state", dbg_state, ARB_RESP);
        d_req = 1'b1;
        do_reset();
        d_req = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
        #1 chk("rst_stray", {i_data_ok, d_data_ok}, 2'b00);
        step();
        m_data_ok = 1'b0;

        // stray response while idle
        m_data_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("idle_stray", {i_data_ok, d_data_ok, dbg_state}, {2'b00, ARB_IDLE});
            step();
        end
        m_data_ok = 1'b0;
        #1 chk("idle_stray_state", dbg_state, ARB_IDLE);

        // random traffic, then drain
        run_cycles(3000, 1'b1, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        run_cycles(10, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
